// File: rtl/lx_mem_scheduler_if.sv
// Bundle of the icache/dcache miss ports and the shared iomem port around lx_mem_scheduler.
// The master modport is the scheduler's view. The slave modport is the caches'/memory's view.
interface lx_mem_scheduler_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BLK_SIZE = 128
);
    logic                ic_valid_i;
    logic [XLEN-1:0]     ic_addr_i;
    logic                ic_ready_o;
    logic [BLK_SIZE-1:0] ic_rdata_o;

    logic                dc_valid_i;
    logic [XLEN-1:0]     dc_addr_i;
    logic [15:0]         dc_wstrb_i;
    logic [BLK_SIZE-1:0] dc_wdata_i;
    logic                dc_ready_o;
    logic [BLK_SIZE-1:0] dc_rdata_o;

    logic                iomem_valid_o;
    logic                iomem_ready_i;
    logic [XLEN-1:0]     iomem_addr_o;
    logic [15:0]         iomem_wstrb_o;
    logic [BLK_SIZE-1:0] iomem_wdata_o;
    logic [BLK_SIZE-1:0] iomem_rdata_i;

    logic                busy_o;

    modport master (
        input  ic_valid_i, ic_addr_i,
        input  dc_valid_i, dc_addr_i, dc_wstrb_i, dc_wdata_i,
        input  iomem_ready_i, iomem_rdata_i,
        output ic_ready_o, ic_rdata_o,
        output dc_ready_o, dc_rdata_o,
        output iomem_valid_o, iomem_addr_o, iomem_wstrb_o, iomem_wdata_o,
        output busy_o
    );

    modport slave (
        output ic_valid_i, ic_addr_i,
        output dc_valid_i, dc_addr_i, dc_wstrb_i, dc_wdata_i,
        output iomem_ready_i, iomem_rdata_i,
        input  ic_ready_o, ic_rdata_o,
        input  dc_ready_o, dc_rdata_o,
        input  iomem_valid_o, iomem_addr_o, iomem_wstrb_o, iomem_wdata_o,
        input  busy_o
    );
endinterface

// File: rtl/lx_mem_scheduler.sv
// Shares the single iomem port between icache and dcache refills.
// The dcache has priority, and the number of cycles the icache can be starved is bounded.
module lx_mem_scheduler #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BLK_SIZE     = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    lx_mem_scheduler_if.master   bus
);
    localparam int unsigned STRB_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]     addr;
        logic [STRB_W-1:0]   wstrb;
        logic [BLK_SIZE-1:0] wdata;
    } req_t;

    state_t           state_q;
    logic             served_d_q;
    logic             valid_q;
    logic [CNT_W-1:0] starve_q;
    req_t             req_q;

    logic ic_cand_c;
    logic dc_cand_c;
    logic grant_i_c;
    logic grant_d_c;
    logic done_c;

    // Candidate selection. In COOL the requester that was just served is masked,
    // because its valid is still high for one cycle after its ready pulse.
    always_comb begin
        ic_cand_c = 1'b0;
        dc_cand_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                ic_cand_c = bus.ic_valid_i;
                dc_cand_c = bus.dc_valid_i;
            end
            S_COOL: begin
                ic_cand_c = bus.ic_valid_i & served_d_q;
                dc_cand_c = bus.dc_valid_i & ~served_d_q;
            end
            default: begin
                ic_cand_c = 1'b0;
                dc_cand_c = 1'b0;
            end
        endcase
        grant_i_c = ic_cand_c & (~dc_cand_c | (starve_q == LIMIT));
        grant_d_c = dc_cand_c & ~grant_i_c;
    end

    // valid_q is only ever high inside GNT_I / GNT_D
    assign done_c = valid_q & bus.iomem_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            served_d_q <= 1'b0;
            valid_q    <= 1'b0;
            req_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_COOL: begin
                    if (grant_d_c) begin
                        state_q <= S_GNT_D;
                        valid_q <= 1'b1;
                        req_q   <= '{addr: bus.dc_addr_i, wstrb: bus.dc_wstrb_i, wdata: bus.dc_wdata_i};
                    end else if (grant_i_c) begin
                        state_q <= S_GNT_I;
                        valid_q <= 1'b1;
                        req_q   <= '{addr: bus.ic_addr_i, wstrb: '0, wdata: '0};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GNT_I, S_GNT_D: begin
                    if (bus.iomem_ready_i) begin
                        valid_q    <= 1'b0;
                        served_d_q <= (state_q == S_GNT_D);
                        state_q    <= S_COOL;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Counts the cycles the icache waits, and saturates at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (grant_i_c) begin
            starve_q <= '0;
        end else if ((state_q == S_IDLE) && !bus.ic_valid_i) begin
            starve_q <= '0;
        end else if (bus.ic_valid_i && (state_q != S_GNT_I) && (starve_q != LIMIT)) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end

    assign bus.iomem_valid_o = valid_q;
    assign bus.iomem_addr_o  = req_q.addr;
    assign bus.iomem_wstrb_o = req_q.wstrb;
    assign bus.iomem_wdata_o = req_q.wdata;
    assign bus.busy_o        = valid_q;

    assign bus.ic_ready_o = done_c & (state_q == S_GNT_I);
    assign bus.dc_ready_o = done_c & (state_q == S_GNT_D);
    assign bus.ic_rdata_o = bus.iomem_rdata_i;
    assign bus.dc_rdata_o = bus.iomem_rdata_i;

endmodule

// File: tb/tb_lx_mem_scheduler.sv
// Directed and randomized bench for lx_mem_scheduler.
// A transaction-level reference model predicts every output on every cycle.
module tb_lx_mem_scheduler;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BLK   = 128;
    localparam int unsigned LIMIT = 4;

    logic clk_i = 1'b0;
    logic rst_ni;

    lx_mem_scheduler_if #(.XLEN(XLEN), .BLK_SIZE(BLK)) bus ();

    lx_mem_scheduler #(.XLEN(XLEN), .BLK_SIZE(BLK), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model. owner/served: 0 = none, 1 = icache, 2 = dcache.
    int unsigned     m_owner;
    int unsigned     m_served;
    int unsigned     m_starve;
    bit              m_cool;
    logic [XLEN-1:0] m_addr;
    logic [15:0]     m_wstrb;
    logic [BLK-1:0]  m_wdata;

    int  order[$];
    int  ic_rdy_cnt = 0;
    int  dc_rdy_cnt = 0;
    int  ic_before;
    int  dc_before;
    bit  ic_seen, ic_after, dc_seen, dc_after;
    int  mem_wait;
    int  exp_alt[4] = '{2, 1, 2, 1};
    int  exp_lim[3] = '{2, 1, 2};

    task automatic check(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_served = 0;
        m_starve = 0;
        m_cool   = 1'b0;
        m_addr   = '0;
        m_wstrb  = '0;
        m_wdata  = '0;
    endtask

    // One clock of the arbitration rules, applied to the inputs present at the edge
    task automatic model_step();
        int unsigned win;
        bit ic, dc;
        ic  = bus.ic_valid_i;
        dc  = bus.dc_valid_i;
        win = 0;
        if (m_owner == 0) begin
            if (m_cool && m_served == 1) ic = 1'b0;
            if (m_cool && m_served == 2) dc = 1'b0;
            if (ic && dc)  win = (m_starve == LIMIT) ? 1 : 2;
            else if (dc)   win = 2;
            else if (ic)   win = 1;
        end
        if (win == 1)                                          m_starve = 0;
        else if (m_owner == 0 && !m_cool && !bus.ic_valid_i)   m_starve = 0;
        else if (bus.ic_valid_i && m_owner != 1)               m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;

        if (m_owner != 0) begin
            if (bus.iomem_ready_i) begin
                m_served = m_owner;
                m_owner  = 0;
                m_cool   = 1'b1;
            end
        end else begin
            m_cool = 1'b0;
            if (win == 2) begin
                m_owner = 2;
                m_addr  = bus.dc_addr_i;
                m_wstrb = bus.dc_wstrb_i;
                m_wdata = bus.dc_wdata_i;
            end else if (win == 1) begin
                m_owner = 1;
                m_addr  = bus.ic_addr_i;
                m_wstrb = '0;
                m_wdata = '0;
            end
        end
    endtask

    task automatic check_outputs();
        check("iomem_valid", BLK'(bus.iomem_valid_o), BLK'(m_owner != 0));
        check("busy",        BLK'(bus.busy_o),        BLK'(m_owner != 0));
        check("iomem_addr",  BLK'(bus.iomem_addr_o),  BLK'(m_addr));
        check("iomem_wstrb", BLK'(bus.iomem_wstrb_o), BLK'(m_wstrb));
        check("iomem_wdata", bus.iomem_wdata_o,       m_wdata);
        check("ic_ready",    BLK'(bus.ic_ready_o),    BLK'(m_owner == 1 && bus.iomem_ready_i));
        check("dc_ready",    BLK'(bus.dc_ready_o),    BLK'(m_owner == 2 && bus.iomem_ready_i));
        check("ic_rdata",    bus.ic_rdata_o,          bus.iomem_rdata_i);
        check("dc_rdata",    bus.dc_rdata_o,          bus.iomem_rdata_i);
        check("starve_cnt",  BLK'(dut.starve_q),      BLK'(m_starve));
    endtask

    // Called just after a falling edge with the inputs already driven
    task automatic tick();
        #1;
        check_outputs();
        if (bus.ic_ready_o === 1'b1) begin ic_rdy_cnt++; ic_seen = 1'b1; order.push_back(1); end
        if (bus.dc_ready_o === 1'b1) begin dc_rdy_cnt++; dc_seen = 1'b1; order.push_back(2); end
        @(posedge clk_i);
        if (rst_ni) model_step();
        @(negedge clk_i);
    endtask

    // Requesters hold valid for one cycle after their ready pulse. Memory answers after 0..3 cycles.
    task automatic rand_drive();
        if (ic_seen) begin
            ic_seen = 1'b0; ic_after = 1'b1;
        end else if (ic_after) begin
            ic_after = 1'b0;
            if ($urandom_range(1) == 1) bus.ic_addr_i = $urandom;
            else                        bus.ic_valid_i = 1'b0;
        end else if (!bus.ic_valid_i && $urandom_range(3) == 0) begin
            bus.ic_valid_i = 1'b1; bus.ic_addr_i = $urandom;
        end

        if (dc_seen) begin
            dc_seen = 1'b0; dc_after = 1'b1;
        end else if (dc_after) begin
            dc_after = 1'b0;
            if ($urandom_range(1) == 1) begin
                bus.dc_addr_i  = $urandom;
                bus.dc_wstrb_i = ($urandom_range(1) == 1) ? 16'($urandom) : 16'h0;
                bus.dc_wdata_i = rand_blk();
            end else begin
                bus.dc_valid_i = 1'b0;
            end
        end else if (!bus.dc_valid_i && $urandom_range(2) == 0) begin
            bus.dc_valid_i = 1'b1;
            bus.dc_addr_i  = $urandom;
            bus.dc_wstrb_i = ($urandom_range(1) == 1) ? 16'($urandom) : 16'h0;
            bus.dc_wdata_i = rand_blk();
        end

        bus.iomem_rdata_i = rand_blk();
        if (bus.iomem_valid_o) begin
            if (mem_wait == 0) begin
                bus.iomem_ready_i = 1'b1;
                mem_wait = int'($urandom_range(3));
            end else begin
                bus.iomem_ready_i = 1'b0;
                mem_wait--;
            end
        end else begin
            bus.iomem_ready_i = ($urandom_range(7) == 0);
        end
    endtask

    initial begin
        rst_ni            = 1'b0;
        bus.ic_valid_i    = 1'b0;
        bus.ic_addr_i     = '0;
        bus.dc_valid_i    = 1'b0;
        bus.dc_addr_i     = '0;
        bus.dc_wstrb_i    = '0;
        bus.dc_wdata_i    = '0;
        bus.iomem_ready_i = 1'b0;
        bus.iomem_rdata_i = '0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single icache read. Memory answers after 3 cycles.
        bus.ic_valid_i = 1'b1;
        bus.ic_addr_i  = 32'h0000_1000;
        tick();
        repeat (3) tick();
        bus.iomem_rdata_i = {16{8'hA5}};
        bus.iomem_ready_i = 1'b1;
        #1;
        check("ic_rdata_a5", bus.ic_rdata_o, {16{8'hA5}});
        tick();
        bus.iomem_ready_i = 1'b0;
        tick();
        bus.ic_valid_i = 1'b0;
        tick();
        check("ic_pulses", BLK'(ic_rdy_cnt), BLK'(1));
        check("dc_pulses", BLK'(dc_rdy_cnt), BLK'(0));

        // dcache write. Request fields must hold even if the inputs wander.
        bus.dc_valid_i = 1'b1;
        bus.dc_addr_i  = 32'h2000_0040;
        bus.dc_wstrb_i = 16'hFFFF;
        bus.dc_wdata_i = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
        tick();
        repeat (2) tick();
        bus.dc_addr_i = 32'hDEAD_BEEF;
        tick();
        bus.dc_addr_i = 32'h2000_0040;
        repeat (2) tick();
        check("dc_addr_hold",  BLK'(bus.iomem_addr_o),  BLK'(32'h2000_0040));
        check("dc_wstrb_hold", BLK'(bus.iomem_wstrb_o), BLK'(16'hFFFF));
        check("dc_wdata_hold", bus.iomem_wdata_o, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
        bus.iomem_ready_i = 1'b1;
        bus.iomem_rdata_i = rand_blk();
        tick();
        bus.iomem_ready_i = 1'b0;
        tick();
        bus.dc_valid_i = 1'b0;
        tick();
        check("dc_write_pulses", BLK'(dc_rdy_cnt), BLK'(1));

        // Both requesting continuously, one-cycle memory: grants alternate
        order.delete();
        bus.dc_wstrb_i = '0;
        bus.ic_valid_i = 1'b1;
        bus.dc_valid_i = 1'b1;
        repeat (12) begin
            bus.iomem_ready_i = bus.iomem_valid_o;
            tick();
        end
        bus.ic_valid_i = 1'b0;
        bus.dc_valid_i = 1'b0;
        repeat (3) begin
            bus.iomem_ready_i = bus.iomem_valid_o;
            tick();
        end
        bus.iomem_ready_i = 1'b0;
        check("alt_count", BLK'(order.size()), BLK'(6));
        for (int i = 0; i < 4; i++) check($sformatf("alt_order_%0d", i), BLK'(order[i]), BLK'(exp_alt[i]));

        // Starvation count saturates while dcache is served, then icache wins in IDLE at the limit
        order.delete();
        bus.ic_valid_i = 1'b1;
        bus.dc_valid_i = 1'b1;
        tick();
        repeat (3) tick();
        bus.iomem_ready_i = 1'b1;
        tick();
        bus.iomem_ready_i = 1'b0;
        bus.ic_valid_i    = 1'b0;
        tick();
        check("starve_sat", BLK'(dut.starve_q), BLK'(LIMIT));
        bus.ic_valid_i = 1'b1;
        tick();
        bus.iomem_ready_i = 1'b1;
        tick();
        bus.iomem_ready_i = 1'b0;
        tick();
        bus.ic_valid_i    = 1'b0;
        bus.iomem_ready_i = 1'b1;
        tick();
        bus.iomem_ready_i = 1'b0;
        bus.dc_valid_i    = 1'b0;
        repeat (2) tick();
        check("lim_count", BLK'(order.size()), BLK'(3));
        for (int i = 0; i < 3; i++) check($sformatf("lim_order_%0d", i), BLK'(order[i]), BLK'(exp_lim[i]));

        // Reset in the middle of a dcache grant abandons it without a ready pulse
        ic_before = ic_rdy_cnt;
        dc_before = dc_rdy_cnt;
        bus.dc_valid_i = 1'b1;
        bus.dc_addr_i  = 32'h4000_0080;
        tick();
        tick();
        #2;
        rst_ni            = 1'b0;
        bus.iomem_ready_i = 1'b1;
        #1;
        model_reset();
        check("rst_iomem_valid", BLK'(bus.iomem_valid_o), BLK'(0));
        check("rst_busy",        BLK'(bus.busy_o),        BLK'(0));
        check("rst_dc_ready",    BLK'(bus.dc_ready_o),    BLK'(0));
        check("rst_addr",        BLK'(bus.iomem_addr_o),  BLK'(0));
        tick();
        bus.dc_valid_i    = 1'b0;
        bus.iomem_ready_i = 1'b0;
        rst_ni            = 1'b1;
        ic_seen = 1'b0;
        dc_seen = 1'b0;
        bus.ic_valid_i = 1'b1;
        bus.ic_addr_i  = 32'h0000_3000;
        tick();
        tick();
        bus.iomem_ready_i = 1'b1;
        tick();
        bus.iomem_ready_i = 1'b0;
        tick();
        bus.ic_valid_i = 1'b0;
        tick();
        check("post_rst_dc_pulses", BLK'(dc_rdy_cnt), BLK'(dc_before));
        check("post_rst_ic_pulses", BLK'(ic_rdy_cnt), BLK'(ic_before + 1));

        // Stray memory ready while idle is ignored
        ic_before = ic_rdy_cnt;
        dc_before = dc_rdy_cnt;
        bus.iomem_ready_i = 1'b1;
        repeat (3) tick();
        bus.iomem_ready_i = 1'b0;
        tick();
        check("idle_ready_ic", BLK'(ic_rdy_cnt), BLK'(ic_before));
        check("idle_ready_dc", BLK'(dc_rdy_cnt), BLK'(dc_before));

        // Randomized traffic against the model
        ic_seen  = 1'b0;
        ic_after = 1'b0;
        dc_seen  = 1'b0;
        dc_after = 1'b0;
        mem_wait = 0;
        repeat (3000) begin
            rand_drive();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
